ov7670_mode_cfg: RTL and testbench



---
 rtl/ov7670_mode_cfg_pkg.sv | 43 ++++
 rtl/ov7670_cfg_rom.sv | 47 ++++
 rtl/ov7670_mode_cfg.sv | 137 +++++++++++++
 tb/tb_ov7670_mode_cfg.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_mode_cfg_pkg.sv
// Shared types and constants for the OV7670 mode-driven register configurator.
// Holds the sequencer state encodings, the register map subset and the mode codes.
package ov7670_mode_cfg_pkg;

  typedef enum logic [2:0] {
    S_SWRST = 3'd0,
    S_WAIT  = 3'd1,
    S_INIT  = 3'd2,
    S_IDLE  = 3'd3,
    S_MODE  = 3'd4
  } cfg_state_e;

  // Sub-phase of a single SCCB register write, shared by every writing state
  typedef enum logic [1:0] {
    W_LOAD  = 2'd0,
    W_ISSUE = 2'd1,
    W_GAP   = 2'd2,
    W_WAIT  = 2'd3
  } wr_phase_e;

  localparam int C_IDX_W = 5;

  localparam logic [7:0] C_REG_COM7    = 8'h12;
  localparam logic [7:0] C_REG_COM15   = 8'h40;
  localparam logic [7:0] C_REG_SCALE_X = 8'h70;
  localparam logic [7:0] C_REG_SCALE_Y = 8'h71;

  localparam logic [7:0] C_COM7_SWRST  = 8'h80;

  localparam logic [1:0] C_MODE_RGB_NORM = 2'b10;
  localparam logic [1:0] C_MODE_YUV_NORM = 2'b00;
  localparam logic [1:0] C_MODE_RGB_TEST = 2'b11;
  localparam logic [1:0] C_MODE_YUV_TEST = 2'b01;

  function automatic logic mode_is_rgb(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_is_test(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// Register table for the OV7670: entries 0-3 follow the applied mode,
// entries 4 onward are fixed 80x60 scaling, clocking and exposure defaults.
module ov7670_cfg_rom
  import ov7670_mode_cfg_pkg::*;
(
  input  logic [C_IDX_W-1:0] index,
  input  logic [1:0]         mode,
  output logic [7:0]         addr,
  output logic [7:0]         data
);

  always_comb begin
    addr = 8'hFF;
    data = 8'hFF;
    case (index)
      5'd0:  begin addr = C_REG_COM7;    data = mode_is_rgb(mode)  ? 8'h04 : 8'h00; end
      5'd1:  begin addr = C_REG_COM15;   data = mode_is_rgb(mode)  ? 8'hD0 : 8'hC0; end
      5'd2:  begin addr = C_REG_SCALE_X; data = mode_is_test(mode) ? 8'hBA : 8'h3A; end
      5'd3:  begin addr = C_REG_SCALE_Y; data = 8'h35; end
      // Clock prescale and downscale path
      5'd4:  begin addr = 8'h11; data = 8'h01; end
      5'd5:  begin addr = 8'h0C; data = 8'h04; end
      5'd6:  begin addr = 8'h3E; data = 8'h1A; end
      5'd7:  begin addr = 8'h72; data = 8'h33; end
      5'd8:  begin addr = 8'h73; data = 8'hF3; end
      5'd9:  begin addr = 8'hA2; data = 8'h02; end
      // Output window
      5'd10: begin addr = 8'h17; data = 8'h16; end
      5'd11: begin addr = 8'h18; data = 8'h04; end
      5'd12: begin addr = 8'h32; data = 8'hA4; end
      5'd13: begin addr = 8'h19; data = 8'h02; end
      5'd14: begin addr = 8'h1A; data = 8'h7A; end
      5'd15: begin addr = 8'h03; data = 8'h0A; end
      // Automatic exposure / gain / white balance
      5'd16: begin addr = 8'h13; data = 8'hE7; end
      5'd17: begin addr = 8'h00; data = 8'h00; end
      5'd18: begin addr = 8'h10; data = 8'h40; end
      5'd19: begin addr = 8'h14; data = 8'h18; end
      5'd20: begin addr = 8'h24; data = 8'h95; end
      5'd21: begin addr = 8'h25; data = 8'h33; end
      5'd22: begin addr = 8'h26; data = 8'hE3; end
      5'd23: begin addr = 8'h3A; data = 8'h04; end
      default: begin addr = 8'hFF; data = 8'hFF; end
    endcase
  end

endmodule

// File: rtl/ov7670_mode_cfg.sv
// Programs the OV7670 over the SCCB master: full init after reset, then only
// the four mode-dependent registers whenever the requested mode changes.
module ov7670_mode_cfg
  import ov7670_mode_cfg_pkg::*;
#(
  parameter int c_wait_cycles = 50000,
  parameter int c_rom_len     = 24,
  parameter int c_mode_len    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rgbmode,
  input  logic       testmode,
  input  logic       sccb_ready,
  output logic       sccb_start,
  output logic [7:0] sccb_addr,
  output logic [7:0] sccb_data,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic [1:0] cfg_mode
);

  localparam int CW = (c_wait_cycles > 1) ? $clog2(c_wait_cycles) : 1;

  // Handshake: sccb_start is high only in W_ISSUE while sccb_ready=1, so the
  // write is accepted in that same cycle. The following cycle (W_GAP) ignores
  // sccb_ready; from then on sccb_ready=1 marks the write complete. addr/data
  // are loaded in W_LOAD and stay put until the next write's W_LOAD.

  cfg_state_e         state, state_nx;
  wr_phase_e          phase, phase_nx;
  logic [C_IDX_W-1:0] idx, idx_nx, last_idx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [1:0]         req_mode, cfg_mode_nx;
  logic [7:0]         addr_nx, data_nx;
  logic [7:0]         rom_addr, rom_data, src_addr, src_data;
  logic               writing;

  ov7670_cfg_rom u_rom (
    .index (idx),
    .mode  (cfg_mode),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  assign writing  = (state == S_SWRST) || (state == S_INIT) || (state == S_MODE);
  assign src_addr = (state == S_SWRST) ? C_REG_COM7   : rom_addr;
  assign src_data = (state == S_SWRST) ? C_COM7_SWRST : rom_data;
  assign last_idx = (state == S_INIT) ? C_IDX_W'(c_rom_len - 1) : C_IDX_W'(c_mode_len - 1);

  assign sccb_start = writing && (phase == W_ISSUE) && sccb_ready;
  assign cfg_busy   = (state != S_IDLE);
  assign cfg_done   = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SWRST;
      phase     <= W_LOAD;
      idx       <= '0;
      cnt       <= CW'(c_wait_cycles - 1);
      req_mode  <= C_MODE_RGB_NORM;
      cfg_mode  <= C_MODE_RGB_NORM;
      sccb_addr <= 8'h00;
      sccb_data <= 8'h00;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      req_mode  <= {rgbmode, testmode};
      cfg_mode  <= cfg_mode_nx;
      sccb_addr <= addr_nx;
      sccb_data <= data_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    phase_nx    = phase;
    idx_nx      = idx;
    cnt_nx      = cnt;
    cfg_mode_nx = cfg_mode;
    addr_nx     = sccb_addr;
    data_nx     = sccb_data;
    case (state)
      S_SWRST, S_INIT, S_MODE: begin
        case (phase)
          W_LOAD: begin
            addr_nx  = src_addr;
            data_nx  = src_data;
            phase_nx = W_ISSUE;
            if (state == S_SWRST) cfg_mode_nx = req_mode;
          end
          W_ISSUE: if (sccb_ready) phase_nx = W_GAP;
          W_GAP:   phase_nx = W_WAIT;
          W_WAIT: begin
            if (sccb_ready) begin
              phase_nx = W_LOAD;
              if (state == S_SWRST) begin
                state_nx = S_WAIT;
                cnt_nx   = CW'(c_wait_cycles - 1);
              end else if (idx == last_idx) begin
                state_nx = S_IDLE;
              end else begin
                idx_nx = idx + C_IDX_W'(1);
              end
            end
          end
          default: phase_nx = W_LOAD;
        endcase
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nx = S_INIT;
          idx_nx   = '0;
          phase_nx = W_LOAD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      // Requests arriving mid-sequence are only looked at here, so the last one wins
      S_IDLE: begin
        if (req_mode != cfg_mode) begin
          cfg_mode_nx = req_mode;
          idx_nx      = '0;
          phase_nx    = W_LOAD;
          state_nx    = S_MODE;
        end
      end
      default: begin
        state_nx = S_SWRST;
        phase_nx = W_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_ov7670_mode_cfg.sv
// Bench for ov7670_mode_cfg: SCCB slave model, write scoreboard, table vectors,
// randomized mode changes and hand-written stall / reset sequences.
module tb_ov7670_mode_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       rgbmode, testmode, sccb_ready;
  logic       sccb_start;
  logic [7:0] sccb_addr, sccb_data;
  logic       cfg_busy, cfg_done;
  logic [1:0] cfg_mode;

  ov7670_mode_cfg dut (
    .clk        (clk),
    .rst        (rst),
    .rgbmode    (rgbmode),
    .testmode   (testmode),
    .sccb_ready (sccb_ready),
    .sccb_start (sccb_start),
    .sccb_addr  (sccb_addr),
    .sccb_data  (sccb_data),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_mode   (cfg_mode)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  int          start_cyc[$];
  int          done_cyc[$];
  logic [1:0]  done_mode_log[$];
  int          n_starts   = 0;
  int          lat        = 4;
  logic        hold_ready = 1'b0;
  logic        prev_start = 1'b0;
  logic        prev_done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] fixed_tab [20] = '{
    16'h1101, 16'h0C04, 16'h3E1A, 16'h7233, 16'h73F3, 16'hA202, 16'h1716,
    16'h1804, 16'h32A4, 16'h1902, 16'h1A7A, 16'h030A, 16'h13E7, 16'h0000,
    16'h1040, 16'h1418, 16'h2495, 16'h2533, 16'h26E3, 16'h3A04};

  function automatic logic [15:0] ref_entry(input int i, input logic [1:0] m);
    logic rgb, tst;
    rgb = m[1];
    tst = m[0];
    case (i)
      0: return {8'h12, rgb ? 8'h04 : 8'h00};
      1: return {8'h40, rgb ? 8'hD0 : 8'hC0};
      2: return {8'h70, tst ? 8'hBA : 8'h3A};
      3: return 16'h7135;
      default: return fixed_tab[i-4];
    endcase
  endfunction

  task automatic push_full(input logic [1:0] m);
    exp_q.push_back(16'h1280);
    for (int i = 0; i < 24; i++) exp_q.push_back(ref_entry(i, m));
  endtask

  task automatic push_mode(input logic [1:0] m);
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_entry(i, m));
  endtask

  // ---------------- SCCB slave model ----------------
  initial begin
    sccb_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (sccb_start) begin
        @(negedge clk);
        sccb_ready = 1'b0;
        repeat (lat - 1) @(negedge clk);
        while (hold_ready) @(negedge clk);
        sccb_ready = 1'b1;
        done_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("busy_done_excl", 32'(cfg_busy & cfg_done), 32'd0);
        if (cfg_done && !prev_done) done_mode_log.push_back(cfg_mode);
        if (sccb_start) begin
          n_starts++;
          start_cyc.push_back(cyc);
          check("start_ready", 32'(sccb_ready), 32'd1);
          check("start_width", 32'(prev_start), 32'd0);
          check("busy_on_write", 32'({cfg_busy, cfg_done}), 32'd2);
          check("write_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0)
            check("write_addr_data", 32'({sccb_addr, sccb_data}), 32'(exp_q.pop_front()));
        end
        prev_start = sccb_start;
        prev_done  = cfg_done;
      end else begin
        prev_start = 1'b0;
        prev_done  = 1'b0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_starts(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (n_starts < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n_starts >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(cfg_done && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic set_mode(input logic [1:0] m);
    rgbmode  = m[1];
    testmode = m[0];
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] w [4];
  } vec_t;

  vec_t vecs [4];
  logic [1:0] cur;

  initial begin
    int s0;
    logic [7:0] snap_a, snap_d;

    vecs[0] = '{mode: 2'b01, w: '{16'h1200, 16'h40C0, 16'h70BA, 16'h7135}};
    vecs[1] = '{mode: 2'b11, w: '{16'h1204, 16'h40D0, 16'h70BA, 16'h7135}};
    vecs[2] = '{mode: 2'b00, w: '{16'h1200, 16'h40C0, 16'h703A, 16'h7135}};
    vecs[3] = '{mode: 2'b10, w: '{16'h1204, 16'h40D0, 16'h703A, 16'h7135}};

    // Reset values
    rst = 1'b1;
    set_mode(2'b10);
    repeat (3) @(negedge clk);
    check("rst_start", 32'(sccb_start), 32'd0);
    check("rst_addr", 32'(sccb_addr), 32'd0);
    check("rst_data", 32'(sccb_data), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd1);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_mode", 32'(cfg_mode), 32'd2);

    // Full init in RGB/normal, with testmode toggled 1->0->1 during S_INIT
    push_full(2'b10);
    push_mode(2'b11);
    rst = 1'b0;
    wait_starts(6, 60000, "reach_init");
    testmode = 1'b1;
    repeat (10) @(negedge clk);
    testmode = 1'b0;
    repeat (10) @(negedge clk);
    testmode = 1'b1;
    wait_idle(3000, "init_idle");
    check("swrst_settle", 32'(start_cyc.size() > 1 && done_cyc.size() > 0
                              && (start_cyc[1] - done_cyc[0]) >= 50000), 32'd1);
    check("init_write_count", 32'(start_cyc.size()), 32'd29);
    check("done_log_len", 32'(done_mode_log.size()), 32'd2);
    if (done_mode_log.size() == 2) begin
      check("init_cfg_mode", 32'(done_mode_log[0]), 32'd2);
      check("toggle_cfg_mode", 32'(done_mode_log[1]), 32'd3);
    end
    check("post_init_busy", 32'(cfg_busy), 32'd0);
    cur = 2'b11;

    // Table-driven mode changes from idle
    for (int v = 0; v < 4; v++) begin
      s0 = n_starts;
      for (int k = 0; k < 4; k++) exp_q.push_back(vecs[v].w[k]);
      set_mode(vecs[v].mode);
      wait_idle(500, "vec_idle");
      repeat (10) @(negedge clk);
      check("vec_writes", 32'(n_starts - s0), 32'd4);
      check("vec_mode", 32'(cfg_mode), 32'(vecs[v].mode));
      check("vec_done", 32'({cfg_busy, cfg_done}), 32'd1);
      cur = vecs[v].mode;
    end

    // Stall: sccb_ready held low for 1000 cycles in the middle of a sequence
    push_mode(2'b00);
    set_mode(2'b00);
    wait_starts(n_starts + 1, 100, "stall_first_start");
    hold_ready = 1'b1;
    for (int n = 0; n < 20 && sccb_ready; n++) @(negedge clk);
    snap_a = sccb_addr;
    snap_d = sccb_data;
    s0 = n_starts;
    repeat (1000) @(negedge clk);
    check("stall_no_start", 32'(n_starts - s0), 32'd0);
    check("stall_addr_data", 32'({sccb_addr, sccb_data}), 32'({snap_a, snap_d}));
    check("stall_ready_low", 32'(sccb_ready), 32'd0);
    hold_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("stall_resume", 32'(n_starts - s0), 32'd1);
    wait_idle(500, "stall_idle");
    check("stall_mode", 32'(cfg_mode), 32'd0);
    cur = 2'b00;

    // Randomized mode requests, sometimes changed again mid-sequence
    for (int it = 0; it < 12; it++) begin
      logic [1:0] m, m2;
      m   = 2'($urandom_range(0, 3));
      lat = $urandom_range(2, 6);
      set_mode(m);
      if (m != cur) begin
        push_mode(m);
        if ($urandom_range(0, 2) == 0) begin
          wait_starts(n_starts + 1, 100, "rand_first_start");
          m2 = 2'($urandom_range(0, 3));
          set_mode(m2);
          if (m2 != m) push_mode(m2);
          m = m2;
        end
        wait_idle(1000, "rand_idle");
      end
      repeat (10) @(negedge clk);
      check("rand_mode", 32'(cfg_mode), 32'(m));
      check("rand_done", 32'(cfg_done), 32'd1);
      cur = m;
    end

    // Reset pulse during S_MODE restarts with the soft reset write
    lat = 4;
    push_mode(~cur);
    set_mode(~cur);
    wait_starts(n_starts + 1, 100, "mode_before_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_start", 32'(sccb_start), 32'd0);
    check("midrst_addr", 32'(sccb_addr), 32'd0);
    check("midrst_data", 32'(sccb_data), 32'd0);
    check("midrst_busy", 32'(cfg_busy), 32'd1);
    check("midrst_done", 32'(cfg_done), 32'd0);
    check("midrst_mode", 32'(cfg_mode), 32'd2);
    exp_q.delete();
    exp_q.push_back(16'h1280);
    @(negedge clk);
    rst = 1'b0;
    wait_starts(n_starts + 1, 100, "swrst_after_rst");
    check("swrst_consumed", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
